// File: rtl/enemy_spawn_scheduler.sv
// Enemy-car spawn scheduler: chooses lane and free sprite slot, pulses that slot's restart
// and holds its X offset. Build macro DIFFICULTY_RAMP_EN shortens the interval every 8 spawns.
module enemy_spawn_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int LANES          = 4,
    parameter int LANE_X0        = 160,
    parameter int LANE_PITCH     = 80,
    parameter int SPAWN_INTERVAL = 90,
`ifdef DIFFICULTY_RAMP_EN
    parameter int MIN_INTERVAL   = 30,
`endif
    parameter int OFFSCREEN_Y    = 620,
    parameter int PENDING_CYC    = 2
) (
    input  logic                    logic_clk,
    input  logic                    reset,
    input  logic                    i_game_run,
    input  logic                    i_collision,
    input  logic [10*NUM_SLOTS-1:0] i_slot_pos_y,
    output logic [NUM_SLOTS-1:0]    o_enemy_en,
    output logic [10*NUM_SLOTS-1:0] o_enemy_x,
    output logic [NUM_SLOTS-1:0]    o_active_mask,
    output logic [7:0]              o_spawn_count,
    output logic                    o_spawn_skipped,
    output logic [7:0]              o_cur_interval
);
    localparam int LB = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int PW = (PENDING_CYC > 1) ? $clog2(PENDING_CYC + 1) : 1;
    localparam logic [9:0]    OFF_Y         = 10'(OFFSCREEN_Y);
    localparam logic [PW-1:0] PEND_MAX      = PW'(PENDING_CYC);
    localparam logic [LB-1:0] LAST_LANE_RST = LB'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_PICK   = 3'd2,
        S_FIRE   = 3'd3,
        S_FROZEN = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_base;
    state_t                  w_next;
    logic                    w_pick_fire;
    logic                    w_fire;
    logic                    w_skip;
    logic [7:0]              r_timer;
    logic [7:0]              r_lfsr;
    logic [7:0]              r_spawn_count;
    logic                    r_spawn_skipped;
    logic [7:0]              w_interval;
    logic [7:0]              w_reload;
    logic [LB-1:0]           r_last_lane;
    logic [LB-1:0]           w_cand;
    logic [LB-1:0]           w_lane;
    logic [NUM_SLOTS-1:0]    w_busy;
    logic                    w_free;
    logic [SW-1:0]           w_slot;
    logic [NUM_SLOTS-1:0]    r_enemy_en;
    logic [10*NUM_SLOTS-1:0] r_enemy_x;
    logic [PW-1:0]           r_pend_cnt [NUM_SLOTS];

    // Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Lane index to screen X offset, truncated to the 10-bit pixel range.
    function automatic logic [9:0] lane_to_x(input logic [LB-1:0] lane);
        int v;
        v = LANE_X0 + int'(lane) * LANE_PITCH;
        return v[9:0];
    endfunction

    assign w_cand   = r_lfsr[LB-1:0];
    assign w_reload = w_interval - 8'd1;

    // Slot occupancy, lowest free slot and the lane that avoids repeating the last one.
    always_comb begin
        w_busy = '0;
        w_free = 1'b0;
        w_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_busy[i] = (i_slot_pos_y[10*i +: 10] < OFF_Y) || (r_pend_cnt[i] != '0);
            w_free    = w_free | ~w_busy[i];
            w_slot    = w_busy[i] ? w_slot : SW'(i);
        end
        w_lane = (w_cand == r_last_lane) ? (w_cand + LB'(1'b1)) : w_cand;
    end

    // Next-state logic; collision freezes and a dropped game_run aborts before any fire.
    always_comb begin
        w_base      = r_state;
        w_pick_fire = 1'b0;
        w_skip      = 1'b0;
        case (r_state)
            S_IDLE:   w_base = i_game_run ? S_WAIT : S_IDLE;
            S_WAIT:   w_base = (r_timer == 8'd0) ? S_PICK : S_WAIT;
            S_PICK: begin
                if (w_free) begin
                    w_base      = S_FIRE;
                    w_pick_fire = 1'b1;
                end else begin
                    w_base = S_WAIT;
                    w_skip = i_game_run & ~i_collision;
                end
            end
            S_FIRE:   w_base = S_WAIT;
            S_FROZEN: w_base = i_game_run ? S_WAIT : S_IDLE;
            default:  w_base = S_IDLE;
        endcase
        w_fire = w_pick_fire & i_game_run & ~i_collision;
        w_next = i_collision ? S_FROZEN : (i_game_run ? w_base : S_IDLE);
    end

    // State register.
    always_ff @(posedge logic_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Spawn timer, LFSR and the per-spawn bookkeeping registers.
    always_ff @(posedge logic_clk) begin
        if (reset) begin
            r_timer         <= 8'(SPAWN_INTERVAL - 1);
            r_lfsr          <= 8'hA5;
            r_last_lane     <= LAST_LANE_RST;
            r_spawn_count   <= 8'd0;
            r_spawn_skipped <= 1'b0;
        end else begin
            r_lfsr          <= lfsr_next(r_lfsr);
            r_spawn_skipped <= w_skip;
            case (r_state)
                S_IDLE: r_timer <= w_reload;
                S_WAIT: r_timer <= (r_timer != 8'd0) ? (r_timer - 8'd1) : r_timer;
                S_PICK: r_timer <= w_skip ? w_reload : r_timer;
                S_FIRE: r_timer <= w_reload;
                default: r_timer <= r_timer;
            endcase
            if (w_fire) begin
                r_last_lane   <= w_lane;
                r_spawn_count <= r_spawn_count + 8'd1;
            end else begin
                r_last_lane   <= r_last_lane;
                r_spawn_count <= r_spawn_count;
            end
        end
    end

    // Per-slot restart pulse, held X offset and post-pulse reservation counter.
    always_ff @(posedge logic_clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) begin
                r_enemy_en[i]        <= 1'b0;
                r_enemy_x[10*i +: 10] <= 10'd0;
                r_pend_cnt[i]        <= '0;
            end else if (w_fire && (w_slot == SW'(i))) begin
                r_enemy_en[i]        <= 1'b1;
                r_enemy_x[10*i +: 10] <= lane_to_x(w_lane);
                r_pend_cnt[i]        <= PEND_MAX;
            end else begin
                r_enemy_en[i]        <= 1'b0;
                r_enemy_x[10*i +: 10] <= r_enemy_x[10*i +: 10];
                r_pend_cnt[i]        <= ((r_state != S_FROZEN) && (r_pend_cnt[i] != '0))
                                        ? (r_pend_cnt[i] - PW'(1'b1)) : r_pend_cnt[i];
            end
        end
    end

`ifdef DIFFICULTY_RAMP_EN
    logic [7:0] r_cur_interval;

    // Each eighth spawn shortens the interval by 4, never below the floor.
    always_ff @(posedge logic_clk) begin
        if (reset) begin
            r_cur_interval <= 8'(SPAWN_INTERVAL);
        end else if (w_fire && (r_spawn_count[2:0] == 3'd7)) begin
            r_cur_interval <= (r_cur_interval >= 8'(MIN_INTERVAL + 4))
                              ? (r_cur_interval - 8'd4) : 8'(MIN_INTERVAL);
        end else begin
            r_cur_interval <= r_cur_interval;
        end
    end

    assign w_interval = r_cur_interval;
`else
    assign w_interval = 8'(SPAWN_INTERVAL);
`endif

    assign o_enemy_en      = r_enemy_en;
    assign o_enemy_x       = r_enemy_x;
    assign o_active_mask   = w_busy;
    assign o_spawn_count   = r_spawn_count;
    assign o_spawn_skipped = r_spawn_skipped;
    assign o_cur_interval  = w_interval;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Scoreboard bench for enemy_spawn_scheduler: a transaction-level model predicts each
// spawn/skip (cycle, slot, X, count, interval); a negedge monitor pops and compares.
module tb_enemy_spawn_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        game_run;
    logic        collision;
    logic [39:0] slot_pos_y;
    logic [3:0]  enemy_en;
    logic [39:0] enemy_x;
    logic [3:0]  active_mask;
    logic [7:0]  spawn_count;
    logic        spawn_skipped;
    logic [7:0]  cur_interval;

    always #5 clk = ~clk;

    enemy_spawn_scheduler dut (
        .logic_clk       (clk),
        .reset           (reset),
        .i_game_run      (game_run),
        .i_collision     (collision),
        .i_slot_pos_y    (slot_pos_y),
        .o_enemy_en      (enemy_en),
        .o_enemy_x       (enemy_x),
        .o_active_mask   (active_mask),
        .o_spawn_count   (spawn_count),
        .o_spawn_skipped (spawn_skipped),
        .o_cur_interval  (cur_interval)
    );

    typedef struct {
        int         ev_cyc;
        int         slot;
        logic [9:0] x;
        logic [7:0] cnt;
        logic [7:0] ival;
    } pulse_t;

    pulse_t     pq[$];
    int         skq[$];
    logic [7:0] skc[$];
    pulse_t     mon_p;
    int         mon_sk;
    logic [7:0] mon_skc;
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    logic [9:0] exp_x [4];
    int         m_count;
    int         m_last;
    int         m_ival;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Edges since the last reset edge; the model indexes time and the LFSR by it.
    always @(posedge clk) edge_cnt <= reset ? 0 : edge_cnt + 1;

    // LFSR value after k shifts from A5 (taps 8,6,5,4), low two bits = lane candidate.
    function automatic int lane_cand(input int k);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return int'(v[1:0]);
    endfunction

    // Outcome of the spawn attempt whose PICK cycle follows edge 'pick'.
    task automatic predict(input int pick, output int ev, output int next_pick);
        int slot;
        int c;
        int lane;
        pulse_t p;
        slot = -1;
        for (int i = 3; i >= 0; i--)
            if (slot_pos_y[10*i +: 10] >= 10'd620) slot = i;
        ev = pick + 1;
        if (slot >= 0) begin
            c    = lane_cand(pick);
            lane = (c == m_last) ? (c + 1) % 4 : c;
            m_last  = lane;
            m_count = (m_count + 1) % 256;
`ifdef DIFFICULTY_RAMP_EN
            if (m_count % 8 == 0) m_ival = (m_ival - 4 < 30) ? 30 : m_ival - 4;
`endif
            p.ev_cyc = ev;
            p.slot   = slot;
            p.x      = 10'(160 + lane * 80);
            p.cnt    = 8'(m_count);
            p.ival   = 8'(m_ival);
            pq.push_back(p);
            next_pick = pick + 2 + m_ival;
        end else begin
            skq.push_back(ev);
            skc.push_back(8'(m_count));
            next_pick = pick + 1 + m_ival;
        end
    endtask

    task automatic wait_edge(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    // Monitor: compare every pulse / skip the DUT presents against the queued prediction.
    always @(negedge clk) begin
        if (enemy_en !== 4'b0000) begin
            if (pq.size() == 0) begin
                chk("unexpected_pulse", 64'(enemy_en), 64'd0);
            end else begin
                mon_p = pq.pop_front();
                chk("pulse_cycle", 64'(edge_cnt), 64'(mon_p.ev_cyc));
                chk("pulse_slot", 64'(enemy_en), 64'(1 << mon_p.slot));
                exp_x[mon_p.slot] = mon_p.x;
                chk("enemy_x", 64'(enemy_x), 64'({exp_x[3], exp_x[2], exp_x[1], exp_x[0]}));
                chk("spawn_count", 64'(spawn_count), 64'(mon_p.cnt));
                chk("cur_interval", 64'(cur_interval), 64'(mon_p.ival));
            end
        end
        if (spawn_skipped === 1'b1) begin
            if (skq.size() == 0) begin
                chk("unexpected_skip", 64'(spawn_skipped), 64'd0);
            end else begin
                mon_sk  = skq.pop_front();
                mon_skc = skc.pop_front();
                chk("skip_cycle", 64'(edge_cnt), 64'(mon_sk));
                chk("skip_count", 64'(spawn_count), 64'(mon_skc));
                chk("skip_no_pulse", 64'(enemy_en), 64'd0);
            end
        end
        if (pq.size() > 0 && pq[0].ev_cyc < edge_cnt) begin
            mon_p = pq.pop_front();
            chk("missed_pulse", 64'(edge_cnt), 64'(mon_p.ev_cyc));
        end
        if (skq.size() > 0 && skq[0] < edge_cnt) begin
            mon_sk  = skq.pop_front();
            mon_skc = skc.pop_front();
            chk("missed_skip", 64'(edge_cnt), 64'(mon_sk));
        end
    end

    initial begin
        int pick;
        int ev;
        int nxt;
        int f;
        reset      = 1'b1;
        game_run   = 1'b0;
        collision  = 1'b0;
        slot_pos_y = {4{10'd620}};
        m_count    = 0;
        m_last     = 3;
        m_ival     = 90;
        for (int i = 0; i < 4; i++) exp_x[i] = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_en", 64'(enemy_en), 64'd0);
        chk("rst_x", 64'(enemy_x), 64'd0);
        chk("rst_count", 64'(spawn_count), 64'd0);
        chk("rst_skip", 64'(spawn_skipped), 64'd0);
        chk("rst_interval", 64'(cur_interval), 64'd90);
        chk("rst_mask", 64'(active_mask), 64'd0);

        // First spawn: game_run rises before edge 1, pulse expected after edge 92.
        reset    = 1'b0;
        game_run = 1'b1;
        predict(91, ev, nxt);
        chk("first_pulse_at_92", 64'(ev), 64'd92);
        wait_edge(ev + 1);
        f = ev;

        // Collision raised while timer shows 40, held 50 cycles; nothing may fire meanwhile.
        wait_edge(f + 50);
        collision = 1'b1;
        wait_edge(f + 99);
        chk("frozen_count", 64'(spawn_count), 64'(m_count));
        wait_edge(f + 100);
        collision = 1'b0;
        pick = f + 51 + m_ival;
        predict(pick, ev, nxt);
        chk("release_latency", 64'(ev - (f + 101) + 1), 64'd42);
        wait_edge(ev + 1);
        pick = nxt;

        // Every slot on screen: only skips, each 91 cycles apart.
        slot_pos_y = {4{10'd100}};
        #1;
        chk("busy_mask", 64'(active_mask), 64'hF);
        for (int n = 0; n < 3; n++) begin
            predict(pick, ev, nxt);
            wait_edge(ev + 1);
            pick = nxt;
        end

        // Random slot occupancy: lane history, slot choice and skips against the model.
        for (int n = 0; n < 130; n++) begin
            for (int i = 0; i < 4; i++)
                slot_pos_y[10*i +: 10] = ($urandom_range(0, 1) == 1)
                    ? 10'($urandom_range(620, 1023)) : 10'($urandom_range(0, 619));
            predict(pick, ev, nxt);
            wait_edge(ev + 1);
            pick = nxt;
        end

        // Reset while the pulse is on screen.
        slot_pos_y = {4{10'd620}};
        predict(pick, ev, nxt);
        wait_edge(ev);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_fire_en", 64'(enemy_en), 64'd0);
        chk("rst_fire_count", 64'(spawn_count), 64'd0);
        chk("rst_fire_x", 64'(enemy_x), 64'd0);
        chk("rst_fire_interval", 64'(cur_interval), 64'd90);
        for (int i = 0; i < 4; i++) exp_x[i] = 10'd0;
        game_run = 1'b0;
        reset    = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_pulse", 64'(enemy_en), 64'd0);
        chk("pending_pulses", 64'(pq.size()), 64'd0);
        chk("pending_skips", 64'(skq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
